// File: rtl/alu_src_fetch_ctrl.sv
// Operand source-fetch sequencer: steps through up to three source-mux selects per instruction.
// Optional WAIT timeout is enabled by defining SRC_FETCH_TIMEOUT_EN.
module alu_src_fetch_ctrl (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_issue_valid,
    input  logic [1:0] i_issue_num_src,
    input  logic [3:0] i_issue_sel0,
    input  logic [3:0] i_issue_sel1,
    input  logic [3:0] i_issue_sel2,
    input  logic       i_flush,
    input  logic       i_rf_rd_valid,
    output logic       o_issue_ready,
    output logic [3:0] o_source_mux_select,
    output logic       o_vgpr_rd_en,
    output logic       o_sgpr_rd_en,
    output logic [2:0] o_src_capture,
    output logic       o_fetch_done,
    output logic       o_sel_error,
`ifdef SRC_FETCH_TIMEOUT_EN
    output logic       o_fetch_timeout,
`endif
    output logic       o_busy
);

    typedef enum logic [1:0] {StIdle, StSel, StWait, StDone} state_e;

    state_e     r_state;
    logic [3:0] r_sel0, r_sel1, r_sel2;
    logic [1:0] r_last;
    logic [1:0] r_idx;
    logic       r_sel_error;

    logic [3:0] w_cur_sel;
    logic       w_illegal, w_is_vgpr, w_is_sgpr, w_is_rf;
    logic       w_in_sel, w_in_wait;
    logic       w_capture_en, w_issue_ready, w_last;

`ifdef SRC_FETCH_TIMEOUT_EN
    logic [3:0] r_tmo;
    logic       w_timeout;
`endif

    always_comb begin
        w_cur_sel = r_sel0;
        case (r_idx)
            2'd1:    w_cur_sel = r_sel1;
            2'd2:    w_cur_sel = r_sel2;
            default: w_cur_sel = r_sel0;
        endcase
    end

    assign w_illegal     = (w_cur_sel[3:2] == 2'b11);
    assign w_is_vgpr     = (w_cur_sel == 4'b0010);
    assign w_is_sgpr     = (w_cur_sel == 4'b0011);
    assign w_is_rf       = w_is_vgpr | w_is_sgpr;
    assign w_in_sel      = (r_state == StSel);
    assign w_in_wait     = (r_state == StWait);
    assign w_last        = (r_idx == r_last);
    assign w_issue_ready = (r_state == StIdle) && !i_flush;

    // Constant sources capture directly in SEL; register-file sources capture when data arrives.
    assign w_capture_en = !i_flush &&
                          ((w_in_sel && !w_illegal && !w_is_rf) || (w_in_wait && i_rf_rd_valid));

`ifdef SRC_FETCH_TIMEOUT_EN
    assign w_timeout       = w_in_wait && !i_flush && !i_rf_rd_valid && (r_tmo == 4'hf);
    assign o_fetch_timeout = w_timeout;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_sel0      <= 4'b0000;
            r_sel1      <= 4'b0000;
            r_sel2      <= 4'b0000;
            r_last      <= 2'd0;
            r_idx       <= 2'd0;
            r_sel_error <= 1'b0;
`ifdef SRC_FETCH_TIMEOUT_EN
            r_tmo       <= 4'd0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_issue_valid && w_issue_ready) begin
                        r_sel0  <= i_issue_sel0;
                        r_sel1  <= i_issue_sel1;
                        r_sel2  <= i_issue_sel2;
                        // A count of zero is treated as a single source.
                        r_last  <= (i_issue_num_src == 2'd0) ? 2'd0 : i_issue_num_src - 2'd1;
                        r_idx   <= 2'd0;
                        r_state <= StSel;
                    end
                end
                StSel: begin
                    if (i_flush) begin
                        r_state <= StIdle;
                    end else if (w_is_rf) begin
                        r_state <= StWait;
`ifdef SRC_FETCH_TIMEOUT_EN
                        r_tmo   <= 4'd0;
`endif
                    end else begin
                        if (w_illegal) begin
                            r_sel_error <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= StDone;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            r_state <= StSel;
                        end
                    end
                end
                StWait: begin
                    if (i_flush) begin
                        r_state <= StIdle;
                    end else if (i_rf_rd_valid) begin
                        if (w_last) begin
                            r_state <= StDone;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            r_state <= StSel;
                        end
                    end
`ifdef SRC_FETCH_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state <= StIdle;
                    end else begin
                        r_tmo <= r_tmo + 4'd1;
                    end
`endif
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        o_source_mux_select = 4'b0000;
        if ((w_in_sel && !w_illegal) || w_in_wait) begin
            o_source_mux_select = w_cur_sel;
        end
    end

    assign o_issue_ready = w_issue_ready;
    assign o_vgpr_rd_en  = w_in_sel && !i_flush && w_is_vgpr;
    assign o_sgpr_rd_en  = w_in_sel && !i_flush && w_is_sgpr;
    assign o_src_capture = w_capture_en ? (3'b001 << r_idx) : 3'b000;
    assign o_fetch_done  = (r_state == StDone) && !i_flush;
    assign o_sel_error   = r_sel_error;
    assign o_busy        = (r_state != StIdle);

endmodule

// File: tb/tb_alu_src_fetch_ctrl.sv
// Directed-vector bench for alu_src_fetch_ctrl; expected output vectors are hand-computed per cycle.
module tb_alu_src_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst, issue_valid, flush, rf_rd_valid;
    logic [1:0] num_src;
    logic [3:0] sel0, sel1, sel2;
    logic       issue_ready, vgpr_rd_en, sgpr_rd_en, fetch_done, sel_error, busy;
    logic [3:0] mux_sel;
    logic [2:0] src_capture;
`ifdef SRC_FETCH_TIMEOUT_EN
    logic       fetch_timeout;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_src_fetch_ctrl u_dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_issue_valid       (issue_valid),
        .i_issue_num_src     (num_src),
        .i_issue_sel0        (sel0),
        .i_issue_sel1        (sel1),
        .i_issue_sel2        (sel2),
        .i_flush             (flush),
        .i_rf_rd_valid       (rf_rd_valid),
        .o_issue_ready       (issue_ready),
        .o_source_mux_select (mux_sel),
        .o_vgpr_rd_en        (vgpr_rd_en),
        .o_sgpr_rd_en        (sgpr_rd_en),
        .o_src_capture       (src_capture),
        .o_fetch_done        (fetch_done),
        .o_sel_error         (sel_error),
`ifdef SRC_FETCH_TIMEOUT_EN
        .o_fetch_timeout     (fetch_timeout),
`endif
        .o_busy              (busy)
    );

    // {ready, select, vgpr, sgpr, capture, done, error, busy}
    logic [12:0] w_obs;
    assign w_obs = {issue_ready, mux_sel, vgpr_rd_en, sgpr_rd_en, src_capture,
                    fetch_done, sel_error, busy};

    function automatic logic [12:0] ev(input logic rdy, input logic [3:0] s, input logic v,
                                       input logic g, input logic [2:0] cap, input logic dn,
                                       input logic er, input logic bz);
        return {rdy, s, v, g, cap, dn, er, bz};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [12:0] e);
        #1;
        check(tag, {19'd0, w_obs}, {19'd0, e});
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [1:0] n, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c);
        issue_valid = 1'b1;
        num_src     = n;
        sel0        = a;
        sel1        = b;
        sel2        = c;
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; flush = 1'b0; rf_rd_valid = 1'b0;
        num_src = 2'd0; sel0 = 4'd0; sel1 = 4'd0; sel2 = 4'd0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        cyc("reset", ev(1, 4'h0, 0, 0, 3'b000, 0, 0, 0));

        // Three constant sources
        issue(2'd3, 4'h0, 4'h1, 4'h7);
        cyc("t1_accept", ev(1, 4'h0, 0, 0, 3'b000, 0, 0, 0));
        issue_valid = 1'b0;
        cyc("t1_cap0", ev(0, 4'h0, 0, 0, 3'b001, 0, 0, 1));
        cyc("t1_cap1", ev(0, 4'h1, 0, 0, 3'b010, 0, 0, 1));
        cyc("t1_cap2", ev(0, 4'h7, 0, 0, 3'b100, 0, 0, 1));
        cyc("t1_done", ev(0, 4'h0, 0, 0, 3'b000, 1, 0, 1));
        cyc("t1_idle", ev(1, 4'h0, 0, 0, 3'b000, 0, 0, 0));

        // VGPR then SGPR, data two cycles after each strobe
        issue(2'd2, 4'h2, 4'h3, 4'h0);
        cyc("t2_accept", ev(1, 4'h0, 0, 0, 3'b000, 0, 0, 0));
        issue_valid = 1'b0;
        cyc("t2_vgpr", ev(0, 4'h2, 1, 0, 3'b000, 0, 0, 1));
        cyc("t2_wait0", ev(0, 4'h2, 0, 0, 3'b000, 0, 0, 1));
        rf_rd_valid = 1'b1;
        cyc("t2_cap0", ev(0, 4'h2, 0, 0, 3'b001, 0, 0, 1));
        cyc("t2_sgpr", ev(0, 4'h3, 0, 1, 3'b000, 0, 0, 1));
        rf_rd_valid = 1'b0;
        cyc("t2_wait1", ev(0, 4'h3, 0, 0, 3'b000, 0, 0, 1));
        rf_rd_valid = 1'b1;
        cyc("t2_cap1", ev(0, 4'h3, 0, 0, 3'b010, 0, 0, 1));
        rf_rd_valid = 1'b0;
        cyc("t2_done", ev(0, 4'h0, 0, 0, 3'b000, 1, 0, 1));
        rf_rd_valid = 1'b1;
        cyc("t2_idle_rf_ignored", ev(1, 4'h0, 0, 0, 3'b000, 0, 0, 0));
        rf_rd_valid = 1'b0;

        // Illegal select
        issue(2'd1, 4'hd, 4'h0, 4'h0);
        cyc("t3_accept", ev(1, 4'h0, 0, 0, 3'b000, 0, 0, 0));
        issue_valid = 1'b0;
        cyc("t3_sel", ev(0, 4'h0, 0, 0, 3'b000, 0, 0, 1));
        cyc("t3_done", ev(0, 4'h0, 0, 0, 3'b000, 1, 1, 1));
        cyc("t3_idle", ev(1, 4'h0, 0, 0, 3'b000, 0, 1, 0));

        // Flush in WAIT of the first source with data arriving the same cycle
        issue(2'd2, 4'h2, 4'h0, 4'h0);
        cyc("t4_accept", ev(1, 4'h0, 0, 0, 3'b000, 0, 1, 0));
        issue_valid = 1'b0;
        cyc("t4_vgpr", ev(0, 4'h2, 1, 0, 3'b000, 0, 1, 1));
        flush = 1'b1; rf_rd_valid = 1'b1;
        cyc("t4_flush", ev(0, 4'h2, 0, 0, 3'b000, 0, 1, 1));
        flush = 1'b0; rf_rd_valid = 1'b0;
        cyc("t4_idle", ev(1, 4'h0, 0, 0, 3'b000, 0, 1, 0));
        issue(2'd1, 4'h5, 4'h0, 4'h0);
        flush = 1'b1;
        cyc("t4_reject", ev(0, 4'h0, 0, 0, 3'b000, 0, 1, 0));
        issue_valid = 1'b0; flush = 1'b0;
        cyc("t4_still_idle", ev(1, 4'h0, 0, 0, 3'b000, 0, 1, 0));

        // Count zero acts as one source
        issue(2'd0, 4'h5, 4'h1, 4'h1);
        cyc("t5_accept", ev(1, 4'h0, 0, 0, 3'b000, 0, 1, 0));
        issue_valid = 1'b0;
        cyc("t5_cap0", ev(0, 4'h5, 0, 0, 3'b001, 0, 1, 1));
        cyc("t5_done", ev(0, 4'h0, 0, 0, 3'b000, 1, 1, 1));
        cyc("t5_idle", ev(1, 4'h0, 0, 0, 3'b000, 0, 1, 0));

        // Reset during SEL of the second source clears everything including sel_error
        issue(2'd3, 4'h0, 4'h0, 4'h0);
        cyc("t6_accept", ev(1, 4'h0, 0, 0, 3'b000, 0, 1, 0));
        issue_valid = 1'b0;
        cyc("t6_cap0", ev(0, 4'h0, 0, 0, 3'b001, 0, 1, 1));
        rst = 1'b1;
        cyc("t6_rst_cycle", ev(0, 4'h0, 0, 0, 3'b010, 0, 1, 1));
        rst = 1'b0;
        cyc("t6_after_rst", ev(1, 4'h0, 0, 0, 3'b000, 0, 0, 0));
        cyc("t6_no_done", ev(1, 4'h0, 0, 0, 3'b000, 0, 0, 0));

`ifdef SRC_FETCH_TIMEOUT_EN
        issue(2'd1, 4'h2, 4'h0, 4'h0);
        cyc("t7_accept", ev(1, 4'h0, 0, 0, 3'b000, 0, 0, 0));
        issue_valid = 1'b0;
        cyc("t7_vgpr", ev(0, 4'h2, 1, 0, 3'b000, 0, 0, 1));
        for (int k = 1; k <= 16; k++) begin
            #1;
            check("t7_timeout", {31'd0, fetch_timeout}, {31'd0, (k == 16)});
            @(posedge clk);
            #2;
        end
        cyc("t7_idle", ev(1, 4'h0, 0, 0, 3'b000, 0, 0, 0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_src_fetch_ctrl.md
ALU_SRC_FETCH_CTRL -- requirements
Module: alu_src_fetch_ctrl

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have issue_valid, input, 1, instruction offered for operand fetch.
REQ-004 SHALL have issue_num_src, input, 2, source count (1..3; 0 treated as 1).
REQ-005 SHALL have issue_sel0/issue_sel1/issue_sel2, input, 4 each, source-mux select codes 0000..1011 per operand.
REQ-006 SHALL have flush, input, 1, abort current fetch.
REQ-007 SHALL have rf_rd_valid, input, 1, register-file read data present on mux input this cycle.
REQ-008 SHALL have issue_ready, output, 1, high only in IDLE with flush low.
REQ-009 SHALL have source_mux_select, output, 4, select driven to the source mux.
REQ-010 SHALL have vgpr_rd_en and sgpr_rd_en, output, 1 each, one-cycle read request strobes.
REQ-011 SHALL have src_capture, output, 3, one-hot strobe latching mux output into operand register i.
REQ-012 SHALL have fetch_done, output, 1, one-cycle pulse after last capture.
REQ-013 SHALL have sel_error, output, 1, sticky flag for illegal select code (1100..1111).
REQ-014 SHALL have busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, SEL, WAIT, DONE.
REQ-016 IDLE: on issue_valid and issue_ready, SHALL latch sel0..2 and count, set index=0, go to SEL next cycle.
REQ-017 SEL: SHALL drive source_mux_select=sel[index]; for 0010 assert vgpr_rd_en, for 0011 assert sgpr_rd_en, go WAIT.
REQ-018 SEL with any other legal code: SHALL assert src_capture[index] in the same cycle and advance.
REQ-019 SEL with illegal code: SHALL set sel_error, drive select 0000, assert no capture, and advance.
REQ-020 WAIT: SHALL hold source_mux_select; on rf_rd_valid assert src_capture[index] same cycle and advance.
REQ-021 Advance: if index==count-1 go DONE, else index+1 and go SEL.
REQ-022 DONE: SHALL pulse fetch_done for exactly one cycle, then go IDLE (issue_ready high the following cycle).
REQ-023 Latency: all-constant instruction with N sources SHALL give fetch_done N+1 cycles after acceptance.
REQ-024 rf_rd_valid outside WAIT SHALL be ignored.
REQ-025 flush in any state SHALL force IDLE next cycle with no capture or fetch_done that cycle; flush with issue_valid SHALL reject the issue.
REQ-026 source_mux_select SHALL be 0000 in IDLE and DONE; at most one src_capture bit SHALL ever be high.
REQ-027 sel_error SHALL clear only on rst.

Reset
REQ-028 rst SHALL force IDLE, index=0, latched selects=0000, and all outputs 0 except issue_ready=1.
REQ-029 rst mid-fetch SHALL discard the fetch; no fetch_done is produced.

Configuration
REQ-030 Macro SRC_FETCH_TIMEOUT_EN: when defined, a 4-bit counter SHALL run in WAIT; after 15 cycles without rf_rd_valid, pulse output fetch_timeout one cycle and go IDLE without fetch_done.
REQ-031 Without SRC_FETCH_TIMEOUT_EN, WAIT SHALL wait indefinitely and fetch_timeout SHALL not exist.

Verification
REQ-032 Issue count=3, sels 0000/0001/0111 -> captures 001,010,100 in cycles 1..3 after acceptance, fetch_done cycle 4.
REQ-033 Issue count=2, sels 0010/0011, rf_rd_valid 2 cycles after each strobe -> vgpr_rd_en then sgpr_rd_en, select held 0010/0011 through WAIT, fetch_done after second capture.
REQ-034 Issue count=1, sel 1101 -> sel_error=1, no capture, fetch_done 2 cycles after acceptance, sel_error stays 1 until rst.
REQ-035 flush in WAIT of source 1 with rf_rd_valid same cycle -> no capture, no fetch_done, issue_ready=1 next cycle.
REQ-036 With SRC_FETCH_TIMEOUT_EN, sel 0010 and rf_rd_valid never -> fetch_timeout pulse 15 cycles into WAIT, then IDLE.
REQ-037 rst asserted during SEL of source 2 -> all outputs reset next cycle, issue_ready=1, no fetch_done.
